keypad_scanner: RTL

Scans a 4x4 active-low matrix keypad and produces a debounced 4-bit key code with a one-cycle valid strobe. It is the input-side counterpart to the time-multiplexed seven-segment output path. It drives one keypad row at a time on a prescaled tick and reads back the columns. It feeds the vending-machine control FSM with coin and selection keys.

---
 rtl/keypad_scanner.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: rotating row drive, debounced press/release, one-clk key_valid strobe.
// Optional auto-repeat while a key is held is compiled in with `define KEYPAD_REPEAT_EN.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   SCAN     | rotating rows on each tick, waiting for any low column
//   DEBOUNCE | row frozen, counting consecutive ticks the latched column is low
//   HELD     | key accepted, waiting for the latched column to go high
//   RELEASE  | counting consecutive ticks the latched column is high
module keypad_scanner #(
   parameter int unsigned SCAN_DIV_W   = 13,
   parameter int unsigned DEBOUNCE_CNT = 4,
   parameter int unsigned REPEAT_TICKS = 64
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   localparam logic [3:0]            DB_N    = 4'(DEBOUNCE_CNT);
   localparam logic [SCAN_DIV_W-1:0] DIV_ONE = {{(SCAN_DIV_W-1){1'b0}}, 1'b1};

   logic [3:0]            col_m;
   logic [3:0]            col_s;
   logic [SCAN_DIV_W-1:0] div_cnt;
   logic                  tick;

   state_t     state;
   state_t     state_nxt;
   logic [1:0] row_idx;
   logic [1:0] row_idx_nxt;
   logic [1:0] lat_col;
   logic [1:0] lat_col_nxt;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;
   logic [3:0] key_code_nxt;
   logic       valid_nxt;
   logic       rpt_fire;

   logic [1:0] col_win;
   logic       col_any;
   logic       lat_low;

   assign tick     = &div_cnt;
   assign row_out  = ~(4'b0001 << row_idx);
   assign key_held = (state == HELD) || (state == RELEASE);
   assign lat_low  = ~col_s[lat_col];

   // Lowest-numbered low column wins when several are pressed together.
   always_comb begin
      col_win = 2'd0;
      col_any = 1'b1;
      if (!col_s[0])
         col_win = 2'd0;
      else if (!col_s[1])
         col_win = 2'd1;
      else if (!col_s[2])
         col_win = 2'd2;
      else if (!col_s[3])
         col_win = 2'd3;
      else
         col_any = 1'b0;
   end

   always_comb begin
      state_nxt    = state;
      row_idx_nxt  = row_idx;
      lat_col_nxt  = lat_col;
      cnt_nxt      = cnt;
      key_code_nxt = key_code;
      valid_nxt    = 1'b0;
      if (tick) begin
         unique case (state)
            SCAN: begin
               if (!col_any) begin
                  row_idx_nxt = row_idx + 2'd1;
               end else begin
                  lat_col_nxt = col_win;
                  if (DB_N == 4'd1) begin
                     key_code_nxt = {row_idx, col_win};
                     valid_nxt    = 1'b1;
                     cnt_nxt      = 4'd0;
                     state_nxt    = HELD;
                  end else begin
                     cnt_nxt   = 4'd1;
                     state_nxt = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (lat_low) begin
                  if (cnt + 4'd1 == DB_N) begin
                     key_code_nxt = {row_idx, lat_col};
                     valid_nxt    = 1'b1;
                     cnt_nxt      = 4'd0;
                     state_nxt    = HELD;
                  end else begin
                     cnt_nxt = cnt + 4'd1;
                  end
               end else begin
                  cnt_nxt     = 4'd0;
                  row_idx_nxt = row_idx + 2'd1;
                  state_nxt   = SCAN;
               end
            end
            HELD: begin
               // A single-tick debounce releases straight back to scanning.
               if (!lat_low) begin
                  if (DB_N == 4'd1) begin
                     cnt_nxt     = 4'd0;
                     row_idx_nxt = row_idx + 2'd1;
                     state_nxt   = SCAN;
                  end else begin
                     cnt_nxt   = 4'd1;
                     state_nxt = RELEASE;
                  end
               end
            end
            RELEASE: begin
               if (!lat_low) begin
                  if (cnt + 4'd1 == DB_N) begin
                     cnt_nxt     = 4'd0;
                     row_idx_nxt = row_idx + 2'd1;
                     state_nxt   = SCAN;
                  end else begin
                     cnt_nxt = cnt + 4'd1;
                  end
               end else begin
                  cnt_nxt   = 4'd0;
                  state_nxt = HELD;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         col_m     <= 4'b1111;
         col_s     <= 4'b1111;
         div_cnt   <= '0;
         state     <= SCAN;
         row_idx   <= 2'd0;
         lat_col   <= 2'd0;
         cnt       <= 4'd0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
      end else begin
         col_m     <= col_in;
         col_s     <= col_m;
         div_cnt   <= div_cnt + DIV_ONE;
         state     <= state_nxt;
         row_idx   <= row_idx_nxt;
         lat_col   <= lat_col_nxt;
         cnt       <= cnt_nxt;
         key_code  <= key_code_nxt;
         key_valid <= valid_nxt | rpt_fire;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   localparam logic [7:0] RPT_N = 8'(REPEAT_TICKS);

   logic [7:0] rpt_cnt;

   // Down-counter reloaded on every entry to HELD; fires on terminal count.
   assign rpt_fire = tick && (state == HELD) && lat_low && (rpt_cnt == 8'd1);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         rpt_cnt <= 8'd0;
      end else if (tick) begin
         if ((state_nxt == HELD) && (state != HELD))
            rpt_cnt <= RPT_N;
         else if ((state == HELD) && lat_low)
            rpt_cnt <= rpt_fire ? RPT_N : rpt_cnt - 8'd1;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

endmodule
